repadd_mult: RTL

Parametrised sequential multiplier that forms `a*b` by repeated addition of the multiplicand into a double-width accumulator, one addition per clock. It is the iterative successor to the team's 16-bit combinational adder. Width is generalised, and the block adds a start/busy/done handshake. An optional operand-swap mode bounds the iteration count by the smaller operand. It sits as a slave datapath unit behind a controller that issues one multiply at a time.

---
 rtl/repadd_pkg.sv | 14 +
 rtl/repadd_mult_add_w.sv | 15 +
 rtl/repadd_mult.sv | 97 +++++++++
 3 files changed

// File: rtl/repadd_pkg.sv
// Shared types and width helpers for the repeated-addition multiplier.
package repadd_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic int PROD_W(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/repadd_mult_add_w.sv
// Parametrised combinational adder of width PROD_W(WIDTH), generalised
// from the earlier fixed 16-bit adder.
module add_w
    import repadd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [PROD_W(WIDTH)-1:0] x,
    input  logic [PROD_W(WIDTH)-1:0] y,
    output logic [PROD_W(WIDTH)-1:0] sum
);

    assign sum = x + y;

endmodule

// File: rtl/repadd_mult.sv
// Sequential multiplier: accumulates the multiplicand once per clock.
// Optional operand swap (min-operand iteration count): define REPADD_SWAP_EN.
module repadd_mult
    import repadd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic                     busy,
    output logic                     done,
    output logic [PROD_W(WIDTH)-1:0] product
);

    localparam int PW = PROD_W(WIDTH);

    state_e           state_q, state_d;
    logic [PW-1:0]    m_q, m_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    product_q, product_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    acc_sum;

    add_w #(.WIDTH(WIDTH)) u_add (
        .x   (acc_q),
        .y   (m_q),
        .sum (acc_sum)
    );

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef REPADD_SWAP_EN
                    // Iterate over the smaller operand to bound latency.
                    if (a < b) begin
                        m_d   = {{WIDTH{1'b0}}, b};
                        cnt_d = a;
                    end else begin
                        m_d   = {{WIDTH{1'b0}}, a};
                        cnt_d = b;
                    end
`else
                    m_d   = {{WIDTH{1'b0}}, a};
                    cnt_d = b;
`endif
                    acc_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q != '0) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q - WIDTH'(1);
                end else begin
                    product_d = acc_q;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

endmodule
